// File: rtl/cpuex_mem_pkg.sv
// Shared types for the core-to-BRAM memory bridge.
package cpuex_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef struct packed {
    logic valid;
    logic we;
    logic err;
  } pipe_entry_t;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } resp_entry_t;

endpackage

// File: rtl/mem_resp_fifo.sv
// Synchronous FIFO with the head entry read directly from the storage registers.
module mem_resp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot that a simultaneous push on a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  no_push_on_full: assert property (@(posedge clk) disable iff (!rstn) !(push && full && !pop));

endmodule

// File: rtl/mem_bridge.sv
// Core load/store port to single-port BRAM bridge with credit-based backpressure
// and an in-order response FIFO that also carries error responses.
module mem_bridge
  import cpuex_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 20,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = RD_LAT + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [WORD_W-1:0]     req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  input  logic [STRB_W-1:0]     req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  bram_en,
  output logic [STRB_W-1:0]     bram_we,
  output logic [DEPTH_LOG2-1:0] bram_addr,
  output logic [WORD_W-1:0]     bram_din,
  input  logic [WORD_W-1:0]     bram_dout
);

  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0] SPAN   = 33'(64'd4 << DEPTH_LOG2);

  logic [CRED_W-1:0] credits_q, credits_d;
  logic              ready_q;
  logic              accept, pop, dec_err;
  logic [31:0]       off;
  pipe_entry_t       pipe_q [RD_LAT];
  pipe_entry_t       pipe_last;
  resp_entry_t       push_entry, head;
  logic              fifo_full, fifo_empty;

  // Request side: decode and drive the BRAM in the accept cycle.
  assign req_ready = ready_q;
  assign accept    = req_valid && ready_q;
  assign off       = req_addr - BASE_ADDR;
  assign dec_err   = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) || ({1'b0, off} >= SPAN);

  assign bram_en   = accept && !dec_err;
  assign bram_we   = (accept && !dec_err && req_we) ? req_wstrb : '0;
  assign bram_addr = off[DEPTH_LOG2+1:2];
  assign bram_din  = req_wdata;

  // Pipeline tracks each request until its BRAM read data is valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{valid: accept, we: req_we, err: dec_err};
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign pipe_last        = pipe_q[RD_LAT-1];
  assign push_entry.rdata = (pipe_last.we || pipe_last.err) ? '0 : bram_dout;
  assign push_entry.err   = pipe_last.err;

  mem_resp_fifo #(
    .WIDTH ($bits(resp_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (pipe_last.valid),
    .din   (push_entry),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (head)
  );

  assign resp_valid = !fifo_empty;
  assign resp_rdata = fifo_empty ? '0 : head.rdata;
  assign resp_err   = !fifo_empty && head.err;
  assign pop        = resp_valid && resp_ready;

  // One credit per FIFO slot; in-flight plus queued responses can never overflow it.
  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!accept && pop) begin
      credits_d = credits_q + CRED_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credits_q <= CRED_W'(FIFO_DEPTH);
      ready_q   <= 1'b0;
    end else begin
      credits_q <= credits_d;
      ready_q   <= (credits_d != '0);
    end
  end

  no_credit_overflow: assert property (@(posedge clk) disable iff (!rstn)
    (credits_q <= CRED_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge with a 256-word, 1-cycle-latency BRAM model.
module tb_mem_bridge;

  localparam int unsigned DL2 = 8;
  localparam int unsigned FD  = 3;

  logic           clk, rstn;
  logic           req_valid, req_ready, req_we;
  logic [31:0]    req_addr, req_wdata;
  logic [3:0]     req_wstrb;
  logic           resp_valid, resp_ready, resp_err;
  logic [31:0]    resp_rdata;
  logic           bram_en;
  logic [3:0]     bram_we;
  logic [DL2-1:0] bram_addr;
  logic [31:0]    bram_din, bram_dout;

  logic [31:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic [32:0] rq [$];
  int          n_cmp, n_err;

  mem_bridge #(
    .DEPTH_LOG2 (DL2),
    .BASE_ADDR  (32'h0000_0000),
    .RD_LAT     (1),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_dout  (bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: read-first, one cycle latency; pl_* preloads words during reset.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
      end
      bram_dout <= mem[bram_addr];
    end
  end

  // Record every response handed to the core as {err, rdata}.
  always @(negedge clk) begin
    if (rstn && resp_valid && resp_ready) rq.push_back({resp_err, resp_rdata});
  end

  function automatic logic [31:0] init_val(input int unsigned i);
    if (i == 4) return 32'hDEAD_BEEF;
    if (i == 2) return 32'h0;
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    resp_ready = 1'b1;
    drive(1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 256; i++) begin
      pl_en = 1'b1;
      pl_addr = 8'(i);
      pl_data = init_val(i);
      tick();
    end
    pl_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    n_cmp++; if (bram_en !== 1'b0) begin n_err++; $display("FAIL rst_bram_en: got %b want 0", bram_en); end
    n_cmp++; if (bram_we !== 4'h0) begin n_err++; $display("FAIL rst_bram_we: got %b want 0000", bram_we); end
    tick();
    req_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rel_ready_same: got %b want 0", req_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready_next: got %b want 1", req_ready); end
    tick();
  endtask

  task automatic test_load();
    rq.delete();
    resp_ready = 1'b1;
    drive(1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL load_ready: got %b want 1", req_ready); end
    n_cmp++; if (bram_en !== 1'b1) begin n_err++; $display("FAIL load_en: got %b want 1", bram_en); end
    n_cmp++; if (bram_addr !== 8'd4) begin n_err++; $display("FAIL load_addr: got %0d want 4", bram_addr); end
    n_cmp++; if (bram_we !== 4'h0) begin n_err++; $display("FAIL load_we: got %b want 0000", bram_we); end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL load_early: got %b want 0", resp_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL load_valid: got %b want 1", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_rdata: got %h want deadbeef", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL load_err: got %b want 0", resp_err); end
    tick();
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL load_after: got %b want 0", resp_valid); end
    n_cmp++; if (rq.size() != 1) begin n_err++; $display("FAIL load_count: got %0d want 1", rq.size()); end
    tick();
  endtask

  task automatic test_store_load();
    logic [32:0] exp [4];
    exp[0] = {1'b0, 32'h0};
    exp[1] = {1'b0, 32'h0022_0044};
    exp[2] = {1'b0, 32'h0};
    exp[3] = {1'b0, 32'hA500_0003};
    rq.delete();
    resp_ready = 1'b1;
    drive(1'b1, 32'h8, 32'h1122_3344, 4'b0101);
    @(negedge clk);
    n_cmp++; if (bram_en !== 1'b1) begin n_err++; $display("FAIL st_en: got %b want 1", bram_en); end
    n_cmp++; if (bram_we !== 4'b0101) begin n_err++; $display("FAIL st_we: got %b want 0101", bram_we); end
    n_cmp++; if (bram_addr !== 8'd2) begin n_err++; $display("FAIL st_addr: got %0d want 2", bram_addr); end
    n_cmp++; if (bram_din !== 32'h1122_3344) begin n_err++; $display("FAIL st_din: got %h want 11223344", bram_din); end
    tick();
    drive(1'b0, 32'h8, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    n_cmp++; if (bram_we !== 4'h0) begin n_err++; $display("FAIL ld_we: got %b want 0000", bram_we); end
    tick();
    drive(1'b1, 32'hC, 32'hFFFF_FFFF, 4'b0000);
    @(negedge clk);
    n_cmp++; if (bram_we !== 4'h0) begin n_err++; $display("FAIL st0_we: got %b want 0000", bram_we); end
    tick();
    drive(1'b0, 32'hC, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    n_cmp++; if (rq.size() != 4) begin n_err++; $display("FAIL stld_count: got %0d want 4", rq.size()); end
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      n_cmp++;
      if (rq[i] !== exp[i]) begin
        n_err++; $display("FAIL stld_resp%0d: got %h want %h", i, rq[i], exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] addr [4];
    logic        we [4];
    logic [32:0] exp [4];
    addr[0] = 32'h6;   we[0] = 1'b0; exp[0] = {1'b1, 32'h0};
    addr[1] = 32'h400; we[1] = 1'b0; exp[1] = {1'b1, 32'h0};
    addr[2] = 32'h3FC; we[2] = 1'b0; exp[2] = {1'b0, 32'hA500_00FF};
    addr[3] = 32'h404; we[3] = 1'b1; exp[3] = {1'b1, 32'h0};
    rq.delete();
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(we[i], addr[i], 32'h5555_5555, 4'hF);
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL err_ready%0d: got %b want 1", i, req_ready); end
      n_cmp++;
      if (bram_en !== exp[i][32] ? 1'b0 : 1'b1) begin
        n_err++; $display("FAIL err_en%0d: got %b want %b", i, bram_en, ~exp[i][32]);
      end
      n_cmp++; if (bram_we !== 4'h0) begin n_err++; $display("FAIL err_we%0d: got %b want 0000", i, bram_we); end
      tick();
    end
    req_valid = 1'b0;
    repeat (4) tick();
    n_cmp++; if (rq.size() != 4) begin n_err++; $display("FAIL err_count: got %0d want 4", rq.size()); end
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      n_cmp++;
      if (rq[i] !== exp[i]) begin
        n_err++; $display("FAIL err_resp%0d: got %h want %h", i, rq[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 32'h20 + 32'(4 * n_acc), 32'h0, 4'h0);
      @(negedge clk);
      if (req_ready) n_acc++;
      tick();
    end
    req_valid = 1'b0;
    n_cmp++; if (n_acc != FD) begin n_err++; $display("FAIL bp_accepted: got %0d want %0d", n_acc, FD); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_stalled: got %b want 0", req_ready); end
    tick();
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== init_val(8 + i)) begin
        n_err++; $display("FAIL bp_drain%0d: got v=%b %h want v=1 %h", i, resp_valid, resp_rdata, init_val(8 + i));
      end
      n_cmp++;
      if (req_ready !== (i != 0)) begin
        n_err++; $display("FAIL bp_ready%0d: got %b want %b", i, req_ready, i != 0);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", resp_valid); end
    tick();
  endtask

  task automatic test_stream();
    int sent = 0, outstanding = 0, max_out = 0, cyc = 0;
    rq.delete();
    while ((sent < 12 || rq.size() < 12) && cyc < 300) begin
      resp_ready = cyc[0];
      drive(1'b0, 32'h40 + 32'(4 * sent), 32'h0, 4'h0);
      req_valid = (sent < 12);
      @(negedge clk);
      if (req_valid && req_ready) begin
        sent++;
        outstanding++;
      end
      if (resp_valid && resp_ready) outstanding--;
      if (outstanding > max_out) max_out = outstanding;
      tick();
      cyc++;
    end
    req_valid = 1'b0;
    n_cmp++; if (cyc >= 300) begin n_err++; $display("FAIL stream_timeout: got %0d cycles want <300", cyc); end
    n_cmp++; if (max_out > FD) begin n_err++; $display("FAIL stream_credits: got %0d want <=%0d", max_out, FD); end
    resp_ready = 1'b1;
    repeat (4) tick();
    n_cmp++; if (rq.size() != 12) begin n_err++; $display("FAIL stream_count: got %0d want 12", rq.size()); end
    for (int i = 0; i < 12 && i < rq.size(); i++) begin
      n_cmp++;
      if (rq[i] !== {1'b0, init_val(16 + i)}) begin
        n_err++; $display("FAIL stream_resp%0d: got %h want %h", i, rq[i], {1'b0, init_val(16 + i)});
      end
    end
  endtask

  task automatic test_reset_mid();
    rq.delete();
    resp_ready = 1'b0;
    drive(1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    drive(1'b0, 32'h14, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    drive(1'b0, 32'h18, 32'h0, 4'h0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_setup: got ready=%b valid=%b want 1 1", req_ready, resp_valid);
    end
    tick();
    req_valid = 1'b0;
    rstn = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b want 0", req_ready); end
    repeat (2) tick();
    rstn = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_rel_same: got %b want 0", req_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_rel_next: got %b want 1", req_ready); end
    repeat (4) tick();
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL mid_stale: got %0d want 0", rq.size()); end
    drive(1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (rq.size() != 1 || rq[0] !== {1'b0, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL mid_fresh: got n=%0d want one response deadbeef", rq.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    resp_ready = 1'b0;
    rstn = 1'b0;
    test_reset();
    test_load();
    test_store_load();
    test_errors();
    test_backpressure();
    test_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
